bcd_conversion_scheduler: RTL and testbench

// - Shares one sequential binary-to-BCD engine (shift-add-3, double dabble) among NUM_REQ requesters.

---
 rtl/bcd_conversion_scheduler.sv | 176 +++++++++++++++++
 tb/tb_bcd_conversion_scheduler.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conversion_scheduler.sv
// Round-robin scheduler sharing one shift-add-3 binary-to-BCD engine.
// Define BCD_SATURATE_EN to saturate overflowing results to all nines.
module bcd_conversion_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int BIN_W   = 16,
    parameter int DIGITS  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*BIN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [4*DIGITS-1:0]      rsp_bcd,
    output logic                     rsp_ovf,
    output logic                     busy
);

    localparam int INT_DIG = (3*BIN_W+9)/10 + 1;
    localparam int ACC_W   = 4*INT_DIG;
    localparam int OUT_W   = 4*DIGITS;
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W   = $clog2(BIN_W+1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ-1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W-1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       sel;
    logic                   found;
    int                     arb_j;
    logic [BIN_W-1:0]       operand;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_adj;
    logic [ACC_W-1:0]       acc_sh;
    logic [BIN_W-1:0]       sreg;
    logic [BIN_W-1:0]       sreg_sh;
    logic [ACC_W+BIN_W-1:0] shifted;
    logic [CNT_W-1:0]       cnt;
    logic                   last_bit;
    logic [OUT_W-1:0]       bcd_raw;
    logic [OUT_W-1:0]       bcd_d;
    logic                   ovf_d;

    // First requester at or after rr_ptr, wrapping once.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        arb_j = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_j = int'(rr_ptr) + i;
            if (arb_j >= NUM_REQ) begin
                arb_j = arb_j - NUM_REQ;
            end
            if (!found && req[arb_j]) begin
                found = 1'b1;
                sel   = IDX_W'(arb_j);
            end
        end
    end

    assign operand = req_data[sel*BIN_W +: BIN_W];

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < INT_DIG; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    assign shifted  = {acc_adj, sreg} << 1;
    assign acc_sh   = shifted[ACC_W+BIN_W-1:BIN_W];
    assign sreg_sh  = shifted[BIN_W-1:0];
    assign last_bit = (cnt == CNT_LAST);
    assign bcd_raw  = OUT_W'(acc_sh);

    generate
        if (INT_DIG > DIGITS) begin : g_hi
            assign ovf_d = |acc_sh[ACC_W-1:OUT_W];
        end else begin : g_nohi
            assign ovf_d = 1'b0;
        end
    endgenerate

`ifdef BCD_SATURATE_EN
    assign bcd_d = ovf_d ? {DIGITS{4'h9}} : bcd_raw;
`else
    assign bcd_d = bcd_raw;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant     = '0;
        rsp_valid = '0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = SHIFT;
                    grant[sel] = reset;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy             = 1'b1;
                rsp_valid[owner] = reset;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result registers load on the edge into DONE so they line up with rsp_valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr  <= '0;
            owner   <= '0;
            acc     <= '0;
            sreg    <= '0;
            cnt     <= '0;
            rsp_bcd <= '0;
            rsp_ovf <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        owner  <= sel;
                        sreg   <= operand;
                        acc    <= '0;
                        cnt    <= '0;
                        rr_ptr <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
                    end
                end
                SHIFT: begin
                    acc  <= acc_sh;
                    sreg <= sreg_sh;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        rsp_bcd <= bcd_d;
                        rsp_ovf <= ovf_d;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conversion_scheduler.sv
// Randomized self-checking bench for bcd_conversion_scheduler.
// Reference results come from decimal arithmetic, honouring BCD_SATURATE_EN.
module tb_bcd_conversion_scheduler;

    localparam int NR  = 3;
    localparam int BW  = 16;
    localparam int DG  = 4;
    localparam int LAT = BW + 1;
    localparam int GAP = BW + 2;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR*BW-1:0] req_data;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    rsp_valid;
    logic [4*DG-1:0]  rsp_bcd;
    logic             rsp_ovf;
    logic             busy;

    int checks;
    int errors;

    typedef struct {
        int owner;
        int data;
        int t;
    } exp_t;

    bcd_conversion_scheduler #(
        .NUM_REQ(NR),
        .BIN_W  (BW),
        .DIGITS (DG)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .rsp_valid(rsp_valid),
        .rsp_bcd  (rsp_bcd),
        .rsp_ovf  (rsp_ovf),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [16:0] ref_conv(input int v);
        int m;
        logic [15:0] b;
        logic o;
        m = v;
        o = (v >= 10000);
        b = '0;
        for (int d = 0; d < DG; d++) begin
            b[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
`ifdef BCD_SATURATE_EN
        if (o) b = 16'h9999;
`endif
        return {o, b};
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic do_grant(input int k, input logic [15:0] d,
                            input logic [15:0] d_after,
                            output logic [NR-1:0] g);
        @(posedge clk); #1;
        req = '0;
        req[k] = 1'b1;
        req_data[k*BW +: BW] = d;
        g = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant !== '0) begin
                g = grant;
                break;
            end
        end
        @(posedge clk); #1;
        req = '0;
        req_data[k*BW +: BW] = d_after;
    endtask

    task automatic wait_rsp(input int start, output int lat,
                            output logic [NR-1:0] v);
        lat = -1;
        v   = '0;
        for (int i = start; i < start + 40; i++) begin
            @(negedge clk);
            if (rsp_valid !== '0) begin
                lat = i;
                v   = rsp_valid;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = '1;
        for (int i = 0; i < NR; i++) req_data[i*BW +: BW] = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (grant !== '0) begin
                errors++;
                $display("FAIL reset_grant: got %b want 000", grant);
            end
        end
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: rsp_valid %b busy %b want 0",
                     rsp_valid, busy);
        end
        checks++;
        if (rsp_bcd !== 16'h0000 || rsp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: got %h/%b want 0000/0",
                     rsp_bcd, rsp_ovf);
        end
        @(posedge clk); #1;
        req   = '0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL reset_idle: busy %b grant %b want 0", busy, grant);
        end
    endtask

    task automatic test_single();
        logic [NR-1:0] g, v;
        logic [16:0] e;
        int lat;
        e = ref_conv(4095);
        do_grant(0, 16'd4095, 16'd4095, g);
        checks++;
        if (g !== 3'b001) begin
            errors++;
            $display("FAIL single_grant: got %b want 001", g);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant !== '0) begin
            errors++;
            $display("FAIL single_busy: busy %b grant %b want 1/000", busy, grant);
        end
        wait_rsp(2, lat, v);
        checks++;
        if (lat !== LAT || v !== 3'b001) begin
            errors++;
            $display("FAIL single_rsp: lat %0d valid %b want %0d/001", lat, v, LAT);
        end
        checks++;
        if (rsp_bcd !== e[15:0] || rsp_ovf !== e[16]) begin
            errors++;
            $display("FAIL single_bcd: got %h/%b want %h/%b",
                     rsp_bcd, rsp_ovf, e[15:0], e[16]);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== '0 || rsp_bcd !== e[15:0]) begin
            errors++;
            $display("FAIL single_hold: valid %b bcd %h want 000/%h",
                     rsp_valid, rsp_bcd, e[15:0]);
        end
    endtask

    task automatic test_boundary();
        int vals [6] = '{0, 9, 65535, 9999, 10000, 1234};
        int ks   [6] = '{1, 2, 1, 0, 2, 2};
        logic [NR-1:0] g, v;
        logic [16:0] e;
        int lat;
        for (int n = 0; n < 6; n++) begin
            e = ref_conv(vals[n]);
            do_grant(ks[n], 16'(vals[n]), (n == 5) ? 16'd9 : 16'(vals[n]), g);
            wait_rsp(1, lat, v);
            checks++;
            if (g !== 3'(1 << ks[n]) || v !== g || lat !== LAT) begin
                errors++;
                $display("FAIL boundary_hs[%0d]: grant %b valid %b lat %0d",
                         vals[n], g, v, lat);
            end
            checks++;
            if (rsp_bcd !== e[15:0] || rsp_ovf !== e[16]) begin
                errors++;
                $display("FAIL boundary_bcd[%0d]: got %h/%b want %h/%b",
                         vals[n], rsp_bcd, rsp_ovf, e[15:0], e[16]);
            end
        end
    endtask

    task automatic test_contention();
        int dat [NR] = '{111, 2222, 33333};
        logic [NR-1:0] gval [4];
        logic [NR-1:0] rval [4];
        logic [15:0]   rbcd [4];
        int gcyc [4];
        int ng, nr;
        logic [16:0] e;
        apply_reset();
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) req_data[i*BW +: BW] = 16'(dat[i]);
        req = '1;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (grant !== '0 && ng < 4) begin
                gval[ng] = grant;
                gcyc[ng] = c;
                ng++;
            end
            if (rsp_valid !== '0 && nr < 4) begin
                rval[nr] = rsp_valid;
                rbcd[nr] = rsp_bcd;
                nr++;
            end
            if (ng == 4 && req !== '0) begin
                @(posedge clk); #1;
                req = '0;
            end
        end
        checks++;
        if (ng != 4 || nr != 4) begin
            errors++;
            $display("FAIL cont_count: grants %0d rsps %0d want 4/4", ng, nr);
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = ref_conv(dat[i % NR]);
                checks++;
                if (gval[i] !== 3'(1 << (i % NR)) || rval[i] !== gval[i]) begin
                    errors++;
                    $display("FAIL cont_order[%0d]: grant %b valid %b want %b",
                             i, gval[i], rval[i], 3'(1 << (i % NR)));
                end
                checks++;
                if (rbcd[i] !== e[15:0]) begin
                    errors++;
                    $display("FAIL cont_bcd[%0d]: got %h want %h", i, rbcd[i], e[15:0]);
                end
                if (i > 0) begin
                    checks++;
                    if (gcyc[i] - gcyc[i-1] != GAP) begin
                        errors++;
                        $display("FAIL cont_gap[%0d]: got %0d want %0d",
                                 i, gcyc[i] - gcyc[i-1], GAP);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midway();
        logic [NR-1:0] g, v;
        int lat, seen;
        do_grant(0, 16'd777, 16'd777, g);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midway_busy: got %b want 0", busy);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid !== '0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midway_discard: rsp_valid pulses %0d want 0", seen);
        end
        do_grant(1, 16'd0, 16'd0, g);
        wait_rsp(1, lat, v);
        checks++;
        if (g !== 3'b010 || v !== 3'b010 || lat !== LAT) begin
            errors++;
            $display("FAIL midway_new: grant %b valid %b lat %0d want 010/010/%0d",
                     g, v, lat, LAT);
        end
        checks++;
        if (rsp_bcd !== 16'h0000 || rsp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL midway_bcd: got %h/%b want 0000/0", rsp_bcd, rsp_ovf);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t en;
        logic [15:0] dat [NR];
        logic pend [NR];
        logic [NR-1:0] exp_g, exp_v;
        logic [16:0] e;
        int ptr, last_g, gk, w, j;
        bit stop;
        apply_reset();
        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b0;
            dat[i]  = '0;
        end
        ptr    = 0;
        last_g = -1000;
        gk     = -1;
        stop   = 1'b0;
        for (int c = 0; c < 1620; c++) begin
            @(posedge clk); #1;
            if (gk >= 0) pend[gk] = 1'b0;
            gk = -1;
            if (c >= 1500) stop = 1'b1;
            for (int i = 0; i < NR; i++) begin
                if (!stop && !pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    case ($urandom_range(0, 5))
                        0: dat[i] = 16'd0;
                        1: dat[i] = 16'd65535;
                        2: dat[i] = 16'd9999;
                        3: dat[i] = 16'd10000;
                        default: dat[i] = 16'($urandom);
                    endcase
                end
                req[i] = pend[i];
                req_data[i*BW +: BW] = dat[i];
            end
            @(negedge clk);
            w = -1;
            for (int off = 0; off < NR; off++) begin
                j = (ptr + off) % NR;
                if (w < 0 && pend[j]) w = j;
            end
            exp_g = (c - last_g >= GAP && w >= 0) ? 3'(1 << w) : '0;
            checks++;
            if (grant !== exp_g) begin
                errors++;
                $display("FAIL rand_grant@%0d: got %b want %b", c, grant, exp_g);
            end
            if (exp_g !== '0) begin
                en.owner = w;
                en.data  = int'(dat[w]);
                en.t     = c;
                q.push_back(en);
                ptr    = (w + 1) % NR;
                last_g = c;
                gk     = w;
            end
            exp_v = '0;
            if (q.size() > 0 && c == q[0].t + LAT) exp_v = 3'(1 << q[0].owner);
            checks++;
            if (rsp_valid !== exp_v) begin
                errors++;
                $display("FAIL rand_valid@%0d: got %b want %b", c, rsp_valid, exp_v);
            end
            if (exp_v !== '0) begin
                en = q.pop_front();
                e  = ref_conv(en.data);
                checks++;
                if (rsp_bcd !== e[15:0] || rsp_ovf !== e[16]) begin
                    errors++;
                    $display("FAIL rand_bcd[%0d]: got %h/%b want %h/%b",
                             en.data, rsp_bcd, rsp_ovf, e[15:0], e[16]);
                end
            end
        end
        req = '0;
        checks++;
        if (q.size() != 0 || pend[0] || pend[1] || pend[2]) begin
            errors++;
            $display("FAIL rand_drain: outstanding %0d want 0", q.size());
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        req      = '0;
        req_data = '0;
        test_reset();
        test_single();
        test_boundary();
        test_contention();
        test_reset_midway();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
